// File: rtl/ysyx_22040386_csr_pkg.sv
// Shared constants for the machine-mode CSR file and trap controller:
// CSR addresses, funct3 encodings, cause codes and the controller state type.
package ysyx_22040386_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_RW   = 3'b001;
    localparam logic [2:0] OP_RS   = 3'b010;
    localparam logic [2:0] OP_RC   = 3'b011;
    localparam logic [2:0] OP_RWI  = 3'b101;
    localparam logic [2:0] OP_RSI  = 3'b110;
    localparam logic [2:0] OP_RCI  = 3'b111;

    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_ECALL   = 5'd11;
    localparam logic [4:0] IRQ_MTI       = 5'd7;
    localparam logic [4:0] IRQ_MEI       = 5'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        WFI
    } state_t;

endpackage

// File: rtl/ysyx_22040386_csr_counter.sv
// Free-running CSR counter with a software load that overrides the increment.
module ysyx_22040386_csr_counter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_value,
    input  logic            inc,
    output logic [XLEN-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            value <= value + XLEN'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040386_csr_trap_unit.sv
// Machine-mode CSR file and trap controller: Zicsr ops, ecall/illegal/interrupt
// traps, mret and wfi, with a registered PC redirect towards the IFU.
module ysyx_22040386_csr_trap_unit
    import ysyx_22040386_csr_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter logic [63:0] MTVEC_RESET  = 64'h0,
    parameter int unsigned HAS_COUNTERS = 1
) (
    input  logic            i_CSR_clk,
    input  logic            i_CSR_rst,
    input  logic            i_CSR_valid,
    input  logic [2:0]      i_CSR_op,
    input  logic [11:0]     i_CSR_addr,
    input  logic [XLEN-1:0] i_CSR_wdata,
    input  logic [4:0]      i_CSR_zimm,
    input  logic            i_CSR_rs1_zero,
    input  logic            i_CSR_ecall,
    input  logic            i_CSR_mret,
    input  logic            i_CSR_wfi,
    input  logic [XLEN-1:0] i_CSR_pc,
    input  logic            i_CSR_mtip,
    input  logic            i_CSR_meip,
    output logic [XLEN-1:0] o_CSR_rdata,
    output logic            o_CSR_reg_write,
    output logic            o_CSR_redirect,
    output logic [XLEN-1:0] o_CSR_dnpc,
    output logic            o_CSR_stall
);

    state_t state_q, state_d;
    logic mst_mie, mst_mpie, mtie, meie;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, wfi_npc_q, mcycle, minstret;
    logic [XLEN-1:0] mip_v, mie_v, pend, rdata, src, new_val, cause_val;
    logic [XLEN-1:0] trap_pc, trap_target, mtvec_base;
    logic legal, at_boundary, csr_op, irq_en, illegal, trap_idle, retire, csr_we;
    logic wfi_wake, wfi_trap, trap_take, trap_irq, mret_take, wfi_take;
    logic [4:0] irq_code, trap_code;

    always_comb begin
        mip_v = '0;
        mip_v[IRQ_MTI] = i_CSR_mtip;
        mip_v[IRQ_MEI] = i_CSR_meip;
        mie_v = '0;
        mie_v[MIE_MTIE] = mtie;
        mie_v[MIE_MEIE] = meie;
    end

    assign pend     = mip_v & mie_v;
    assign irq_en   = mst_mie && (|pend);
    assign irq_code = pend[IRQ_MEI] ? IRQ_MEI : IRQ_MTI;

    always_comb begin
        rdata = '0;
        legal = 1'b1;
        case (i_CSR_addr)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]  = mst_mie;
                rdata[MSTATUS_MPIE] = mst_mpie;
                rdata[12:11]        = 2'b11;
            end
            CSR_MIE:      rdata = mie_v;
            CSR_MIP:      rdata = mip_v;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MCYCLE: begin
                if (HAS_COUNTERS != 0) rdata = mcycle;
                else legal = 1'b0;
            end
            CSR_MINSTRET: begin
                if (HAS_COUNTERS != 0) rdata = minstret;
                else legal = 1'b0;
            end
            default:      legal = 1'b0;
        endcase
    end

    assign at_boundary = (state_q == IDLE) && i_CSR_valid;
    assign csr_op      = at_boundary && (i_CSR_op != OP_NONE);
    assign illegal     = csr_op && !legal;
    assign trap_idle   = at_boundary && (irq_en || illegal || i_CSR_ecall);
    assign retire      = at_boundary && !trap_idle;

    assign src = i_CSR_op[2] ? XLEN'(i_CSR_zimm) : i_CSR_wdata;

    always_comb begin
        case (i_CSR_op[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = rdata | src;
            2'b11:   new_val = rdata & ~src;
            default: new_val = rdata;
        endcase
    end

    // Set/clear forms with a zero source read only; writes (RW/RWI) always land.
    assign csr_we = retire && (i_CSR_op != OP_NONE) &&
                    ((i_CSR_op[1:0] == 2'b01) || !i_CSR_rs1_zero);

    assign o_CSR_rdata     = rdata;
    assign o_CSR_reg_write = retire && (i_CSR_op != OP_NONE);

    assign wfi_wake   = (state_q == WFI) && (|pend);
    assign wfi_trap   = wfi_wake && mst_mie;
    assign trap_take  = trap_idle || wfi_trap;
    assign trap_irq   = (at_boundary && irq_en) || wfi_trap;
    assign trap_code  = trap_irq ? irq_code : (illegal ? CAUSE_ILLEGAL : CAUSE_ECALL);
    assign trap_pc    = (state_q == WFI) ? wfi_npc_q : i_CSR_pc;
    assign mret_take  = retire && i_CSR_mret;
    assign wfi_take   = retire && i_CSR_wfi;
    assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = (trap_irq && (mtvec_q[1:0] == 2'b01))
                         ? mtvec_base + (XLEN'(trap_code) << 2) : mtvec_base;

    always_comb begin
        cause_val = XLEN'(trap_code);
        cause_val[XLEN-1] = trap_irq;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (trap_take || mret_take) state_d = REDIRECT;
                else if (wfi_take)          state_d = WFI;
            end
            REDIRECT: state_d = IDLE;
            WFI: begin
                if (wfi_trap)      state_d = REDIRECT;
                else if (wfi_wake) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CSR_clk) begin
        if (i_CSR_rst) begin
            state_q        <= IDLE;
            o_CSR_redirect <= 1'b0;
            o_CSR_stall    <= 1'b0;
            o_CSR_dnpc     <= '0;
        end else begin
            state_q        <= state_d;
            o_CSR_redirect <= (state_d == REDIRECT);
            o_CSR_stall    <= (state_d != IDLE);
            if (trap_take)      o_CSR_dnpc <= trap_target;
            else if (mret_take) o_CSR_dnpc <= mepc_q;
        end
    end

    always_ff @(posedge i_CSR_clk) begin
        if (i_CSR_rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mtie       <= 1'b0;
            meie       <= 1'b0;
            mtvec_q    <= MTVEC_RESET[XLEN-1:0];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            wfi_npc_q  <= '0;
        end else begin
            if (wfi_take) wfi_npc_q <= i_CSR_pc + XLEN'(4);
            if (trap_take) begin
                mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
                mcause_q <= cause_val;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_take) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (csr_we) begin
                case (i_CSR_addr)
                    CSR_MSTATUS: begin
                        mst_mie  <= new_val[MSTATUS_MIE];
                        mst_mpie <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE: begin
                        mtie <= new_val[MIE_MTIE];
                        meie <= new_val[MIE_MEIE];
                    end
                    CSR_MTVEC: mtvec_q <= {new_val[XLEN-1:2],
                                           new_val[1] ? mtvec_q[1:0] : new_val[1:0]};
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    CSR_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    default: ;
                endcase
            end
        end
    end

    generate
        if (HAS_COUNTERS != 0) begin : g_counters
            ysyx_22040386_csr_counter #(.XLEN(XLEN)) u_mcycle (
                .clk        (i_CSR_clk),
                .rst        (i_CSR_rst),
                .load       (csr_we && (i_CSR_addr == CSR_MCYCLE)),
                .load_value (new_val),
                .inc        (1'b1),
                .value      (mcycle)
            );
            ysyx_22040386_csr_counter #(.XLEN(XLEN)) u_minstret (
                .clk        (i_CSR_clk),
                .rst        (i_CSR_rst),
                .load       (csr_we && (i_CSR_addr == CSR_MINSTRET)),
                .load_value (new_val),
                .inc        (retire),
                .value      (minstret)
            );
        end else begin : g_no_counters
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

endmodule

// File: tb/tb_ysyx_22040386_csr_trap_unit.sv
// Scoreboard bench: a behavioural CSR/trap model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_ysyx_22040386_csr_trap_unit;

    localparam logic [63:0] MTVEC_RST = 64'h8000_0000;
    localparam int RUN = 0, JUMP = 1, SLEEP = 2;

    logic        clk = 1'b0;
    logic        rst, valid, rs1z, ecall, mret, wfi, mtip, meip;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [63:0] wdata, pc, rdata, dnpc;
    logic [4:0]  zimm;
    logic        reg_write, redirect, stall;

    ysyx_22040386_csr_trap_unit #(
        .XLEN         (64),
        .MTVEC_RESET  (MTVEC_RST),
        .HAS_COUNTERS (1)
    ) dut (
        .i_CSR_clk       (clk),
        .i_CSR_rst       (rst),
        .i_CSR_valid     (valid),
        .i_CSR_op        (op),
        .i_CSR_addr      (addr),
        .i_CSR_wdata     (wdata),
        .i_CSR_zimm      (zimm),
        .i_CSR_rs1_zero  (rs1z),
        .i_CSR_ecall     (ecall),
        .i_CSR_mret      (mret),
        .i_CSR_wfi       (wfi),
        .i_CSR_pc        (pc),
        .i_CSR_mtip      (mtip),
        .i_CSR_meip      (meip),
        .o_CSR_rdata     (rdata),
        .o_CSR_reg_write (reg_write),
        .o_CSR_redirect  (redirect),
        .o_CSR_dnpc      (dnpc),
        .o_CSR_stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        valid;
        bit [2:0]  op;
        bit [11:0] addr;
        bit [63:0] wdata;
        bit [4:0]  zimm;
        bit        rs1z, ecall, mret, wfi;
        bit [63:0] pc;
    } ins_t;

    typedef struct {
        bit        chk;
        bit        chk_rd;
        bit [63:0] rdata;
        bit        reg_write;
        bit        redirect;
        bit        chk_dnpc;
        bit [63:0] dnpc;
        bit        stall;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   lvl_mtip = 1'b0, lvl_meip = 1'b0;

    bit [63:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mcycle, r_minstret, r_wfi_ret, m_dnpc;
    bit        r_gie, r_pie, m_redirect, m_stall;
    int        m_mode;

    function automatic void model_reset();
        r_mie = 0; r_mtvec = MTVEC_RST; r_mscratch = 0; r_mepc = 0; r_mcause = 0;
        r_mcycle = 0; r_minstret = 0; r_wfi_ret = 0; m_dnpc = 0;
        r_gie = 0; r_pie = 0; m_redirect = 0; m_stall = 0; m_mode = RUN;
    endfunction

    function automatic bit [63:0] cur_mip();
        return (lvl_mtip ? 64'h80 : 64'h0) | (lvl_meip ? 64'h800 : 64'h0);
    endfunction

    function automatic bit model_read(input bit [11:0] a, output bit [63:0] v);
        v = 0;
        case (a)
            12'h300: v = (64'(r_gie) << 3) | (64'(r_pie) << 7) | 64'h1800;
            12'h304: v = r_mie;
            12'h344: v = cur_mip();
            12'h305: v = r_mtvec;
            12'h340: v = r_mscratch;
            12'h341: v = r_mepc;
            12'h342: v = r_mcause;
            12'hB00: v = r_mcycle;
            12'hB02: v = r_minstret;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One clock of architectural behaviour: expected outputs now, state after the edge.
    task automatic model_step(input ins_t s, output exp_t e);
        bit [63:0] pend, old, src, nv, base, tpc;
        bit legal, is_irq, trap, retire, cyc_w, ins_w;
        int code;
        e = '{default: 0};
        e.chk = 1; e.redirect = m_redirect; e.chk_dnpc = m_redirect;
        e.dnpc = m_dnpc; e.stall = m_stall;
        pend   = r_mie & cur_mip();
        code   = pend[11] ? 11 : 7;
        is_irq = 0; trap = 0; retire = 0; cyc_w = 0; ins_w = 0; tpc = s.pc;
        legal  = model_read(s.addr, old);
        if (m_mode == JUMP) begin
            m_mode = RUN; m_redirect = 0; m_stall = 0;
        end else if (m_mode == SLEEP) begin
            if (pend != 0) begin
                if (r_gie) begin
                    trap = 1; is_irq = 1; tpc = r_wfi_ret;
                end else begin
                    m_mode = RUN; m_stall = 0;
                end
            end
        end else if (s.valid) begin
            if (r_gie && pend != 0) begin
                trap = 1; is_irq = 1;
            end else if (s.op != 0 && !legal) begin
                trap = 1; code = 2;
            end else if (s.ecall) begin
                trap = 1; code = 11;
            end else begin
                retire = 1;
                if (s.op != 0) begin
                    e.reg_write = 1; e.chk_rd = 1; e.rdata = old;
                    src = s.op[2] ? 64'(s.zimm) : s.wdata;
                    case (s.op[1:0])
                        2'd1:    nv = src;
                        2'd2:    nv = old | src;
                        default: nv = old & ~src;
                    endcase
                    if (s.op[1:0] == 2'd1 || !s.rs1z) begin
                        case (s.addr)
                            12'h300: begin r_gie = nv[3]; r_pie = nv[7]; end
                            12'h304: r_mie = nv & 64'h880;
                            12'h305: r_mtvec = {nv[63:2], nv[1] ? r_mtvec[1:0] : nv[1:0]};
                            12'h340: r_mscratch = nv;
                            12'h341: r_mepc = {nv[63:2], 2'b00};
                            12'h342: r_mcause = nv;
                            12'hB00: begin r_mcycle = nv; cyc_w = 1; end
                            12'hB02: begin r_minstret = nv; ins_w = 1; end
                            default: ;
                        endcase
                    end
                end
                if (s.mret) begin
                    r_gie = r_pie; r_pie = 1; m_dnpc = r_mepc;
                    m_mode = JUMP; m_redirect = 1; m_stall = 1;
                end else if (s.wfi) begin
                    r_wfi_ret = s.pc + 4; m_mode = SLEEP; m_stall = 1;
                end
            end
        end
        if (trap) begin
            base = {r_mtvec[63:2], 2'b00};
            m_dnpc = (is_irq && r_mtvec[1:0] == 2'b01) ? base + 64'(4 * code) : base;
            r_mepc = {tpc[63:2], 2'b00};
            r_mcause = is_irq ? (64'h8000_0000_0000_0000 | 64'(code)) : 64'(code);
            r_pie = r_gie; r_gie = 0;
            m_mode = JUMP; m_redirect = 1; m_stall = 1;
        end
        if (!cyc_w) r_mcycle = r_mcycle + 1;
        if (!ins_w && retire) r_minstret = r_minstret + 1;
    endtask

    task automatic step(input ins_t s);
        exp_t e;
        valid = s.valid; op = s.op; addr = s.addr; wdata = s.wdata; zimm = s.zimm;
        rs1z = s.rs1z; ecall = s.ecall; mret = s.mret; wfi = s.wfi; pc = s.pc;
        mtip = lvl_mtip; meip = lvl_meip;
        model_step(s, e);
        sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        exp_t e = '{default: 0};
        rst = 1; valid = 0; op = 0; addr = 0; wdata = 0; zimm = 0; rs1z = 0;
        ecall = 0; mret = 0; wfi = 0; pc = 0; mtip = lvl_mtip; meip = lvl_meip;
        sb.push_back(e); @(posedge clk); #1;
        sb.push_back(e); @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    function automatic ins_t mk_csr(input bit [2:0] o, input bit [11:0] a, input bit [63:0] d);
        ins_t s = '{default: 0};
        s.valid = 1; s.op = o; s.addr = a; s.wdata = d; s.zimm = d[4:0];
        s.rs1z = o[2] ? (d[4:0] == 0) : (d == 0);
        s.pc = 64'h1000;
        return s;
    endfunction

    function automatic ins_t mk_ctl(input bit ec, input bit mr, input bit wf, input bit [63:0] p);
        ins_t s = '{default: 0};
        s.valid = 1; s.ecall = ec; s.mret = mr; s.wfi = wf; s.pc = p;
        return s;
    endfunction

    function automatic ins_t mk_idle();
        ins_t s = '{default: 0};
        return s;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t s = '{default: 0};
        int k;
        s.valid = ($urandom_range(0, 99) < 85);
        s.pc = {32'h0, $urandom} & ~64'h3;
        k = $urandom_range(0, 39);
        if (k == 0) s.ecall = 1;
        else if (k == 1) s.mret = 1;
        else if (k == 2) s.wfi = 1;
        else begin
            case ($urandom_range(0, 6))
                0: s.op = 3'b000; 1: s.op = 3'b001; 2: s.op = 3'b010; 3: s.op = 3'b011;
                4: s.op = 3'b101; 5: s.op = 3'b110; default: s.op = 3'b111;
            endcase
            case ($urandom_range(0, 10))
                0: s.addr = 12'h300; 1: s.addr = 12'h304; 2: s.addr = 12'h305;
                3: s.addr = 12'h340; 4: s.addr = 12'h341; 5: s.addr = 12'h342;
                6: s.addr = 12'h344; 7: s.addr = 12'hB00; 8: s.addr = 12'hB02;
                9: s.addr = 12'h7C0; default: s.addr = 12'h301;
            endcase
            s.wdata = {$urandom, $urandom};
            s.zimm = 5'($urandom);
            s.rs1z = ($urandom_range(0, 3) == 0);
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("reg_write", 64'(reg_write), 64'(e.reg_write));
                check("redirect", 64'(redirect), 64'(e.redirect));
                check("stall", 64'(stall), 64'(e.stall));
                if (e.chk_dnpc) check("dnpc", dnpc, e.dnpc);
                if (e.chk_rd) check("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sleep_len;
        rst = 1;
        @(posedge clk); #1;
        do_reset();

        step(mk_csr(3'b010, 12'h305, 0));
        step(mk_csr(3'b001, 12'h340, 64'hDEAD));
        step(mk_csr(3'b010, 12'h340, 64'h00F0));
        step(mk_csr(3'b010, 12'h340, 0));

        step(mk_csr(3'b001, 12'h305, 64'h100));
        step(mk_ctl(1, 0, 0, 64'h2000));
        step(mk_idle());
        step(mk_csr(3'b010, 12'h341, 0));
        step(mk_csr(3'b010, 12'h342, 0));
        step(mk_csr(3'b010, 12'h300, 0));

        step(mk_csr(3'b001, 12'h305, 64'h101));
        step(mk_csr(3'b010, 12'h304, 64'h80));
        step(mk_csr(3'b110, 12'h300, 64'h8));
        lvl_mtip = 1;
        step(mk_ctl(0, 0, 0, 64'h40));
        lvl_mtip = 0;
        step(mk_idle());
        step(mk_csr(3'b010, 12'h342, 0));
        step(mk_ctl(0, 1, 0, 64'h1000));
        step(mk_idle());
        step(mk_csr(3'b010, 12'h300, 0));

        step(mk_csr(3'b001, 12'h305, 64'h200));
        step(mk_csr(3'b001, 12'h304, 64'h800));
        step(mk_ctl(0, 0, 1, 64'h80));
        repeat (5) step(mk_idle());
        lvl_meip = 1;
        step(mk_idle());
        lvl_meip = 0;
        step(mk_idle());
        step(mk_csr(3'b010, 12'h341, 0));
        step(mk_csr(3'b010, 12'h342, 0));

        step(mk_csr(3'b001, 12'hB00, '1));
        step(mk_csr(3'b010, 12'hB00, 0));
        step(mk_csr(3'b010, 12'hB00, 0));
        step(mk_csr(3'b001, 12'h7C0, 64'h5));
        step(mk_idle());
        step(mk_csr(3'b010, 12'h344, 64'hFFF));
        step(mk_csr(3'b001, 12'h305, 64'h3));
        step(mk_csr(3'b010, 12'h305, 0));
        step(mk_csr(3'b001, 12'h341, 64'h1237));
        step(mk_csr(3'b011, 12'h341, 0));
        step(mk_csr(3'b010, 12'hB02, 0));

        step(mk_csr(3'b001, 12'h300, 0));
        step(mk_csr(3'b001, 12'h304, 64'h80));
        step(mk_ctl(0, 0, 1, 64'h300));
        step(mk_idle());
        lvl_mtip = 1;
        step(mk_idle());
        lvl_mtip = 0;
        step(mk_csr(3'b010, 12'h300, 0));

        step(mk_csr(3'b001, 12'h304, 0));
        step(mk_ctl(0, 0, 1, 64'h400));
        step(mk_idle());
        do_reset();
        step(mk_csr(3'b010, 12'h305, 0));

        sleep_len = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 24) == 0) lvl_mtip = ~lvl_mtip;
            if ($urandom_range(0, 29) == 0) lvl_meip = ~lvl_meip;
            sleep_len = (m_mode == SLEEP) ? sleep_len + 1 : 0;
            if (sleep_len > 15 || $urandom_range(0, 199) == 0) begin
                do_reset();
                sleep_len = 0;
            end else begin
                step(rnd_ins());
            end
        end

        @(negedge clk); #1;
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
